tank_bullets: RTL
=================

# tank_bullets

Projectile engine sitting directly downstream of the tank movement block. It consumes the tank centre position and 22-step heading index plus the raw 4-byte USB keycode word. On each fire-key press it spawns a bullet at the tank centre, moves every live bullet once per frame with wall bounce, and retires bullets after a fixed lifetime. Bullet positions and valid flags go to the colour mapper / renderer.

## Interface
- NUM_BULLETS, 4: number of bullet slots (1..8).
- FIRE_KEY, 8'h2C: USB HID code that fires (space).
- SPEED, 4: bullet speed magnitude in pixels/frame (1..7).
- LIFETIME, 240: frames a bullet stays live (1..1023).
- COOLDOWN, 15: frames after a shot during which fire is ignored (0..255).
- X_MIN / X_MAX, 0 / 639: horizontal arena bounds.
- Y_MIN / Y_MAX, 0 / 479: vertical arena bounds.

Ports:
- frame_clk  in  1  frame-rate clock; only clock.
- Reset  in  1  synchronous, active-high reset.
- keycode  in  32  four packed HID key bytes.
- TankX  in  10  tank centre X.
- TankY  in  10  tank centre Y.
- Angle  in  5  heading index 0..21, counter-clockwise, 0 = +X.
- BulletX  out  10*NUM_BULLETS  slot i X at [10i+9:10i].
- BulletY  out  10*NUM_BULLETS  slot i Y, same packing.
- BulletActive  out  NUM_BULLETS  slot valid flags.
- Fired  out  1  one-cycle pulse on the edge a bullet spawns.

## Operation
- Fire detect: fire_now = any keycode byte == FIRE_KEY. Register fire_prev. A press is fire_now & ~fire_prev. Holding the key gives one press only.
- Accept: press & (cooldown == 0) & (a free slot exists). The free-slot mask is taken from the current registered BulletActive, so a slot expiring on this edge is not reusable on this edge. A rejected press is dropped, not queued.
- Allocation: lowest-index inactive slot.
- Spawn into the chosen slot:
  - X = TankX, Y = TankY.
  - DX/DY = VEL[Angle], where Angle >= 22 is treated as 0.
  - life = LIFETIME; active = 1.
  - cooldown = COOLDOWN; Fired = 1.
  - The spawned slot does not move on its spawn edge.
- Velocity table: 22 entries of signed 4-bit (DX, DY).
  - θk = k·360/22 degrees.
  - DX = round(SPEED·cos θk), DY = −round(SPEED·sin θk); screen Y grows downward.
  - Rounding is half away from zero. The table is a constant ROM.
  - SPEED=4 anchors: k=0 → (4,0); k=11 → (−4,0); k=5 → (1,−4); k=16 → (−1,4).
- Per live slot, each non-spawn edge:
  - If life == 1: active ← 0, life ← 0, and the slot does not move.
  - Otherwise life ← life−1, then move.
  - Move X: nx = X + sext(DX) computed at 11 bits signed. If nx < X_MIN or nx > X_MAX, X is held and DX ← −DX. Otherwise X ← nx.
  - Move Y: the same rule, independently, with Y_MIN / Y_MAX. A corner hit flips both components.
- Cooldown decrements by 1 per edge while nonzero; it saturates at 0.
- Inactive slots hold their X/Y/DX/DY unchanged. Outputs expose stored X/Y regardless of BulletActive.

## Timing
- All state updates on posedge frame_clk. Outputs are registered, with zero combinational paths from inputs to outputs.
- Spawn latency: press on edge n → BulletActive[i] = 1 and BulletX/Y = TankX/TankY sampled at edge n, visible after edge n. First move is at edge n+1.
- Active span: a bullet spawned at edge n is active after edges n .. n+LIFETIME−1 and cleared at edge n+LIFETIME.
- Next accepted shot: edge n+COOLDOWN+1 at the earliest. With COOLDOWN=0, the next press edge is accepted.
- Fired is high exactly for the cycle following an accept edge.
- Reset (any cycle, including mid-flight):
  - BulletActive = 0; BulletX/Y = 0; all DX/DY = 0; life = 0.
  - cooldown = 0; fire_prev = 0; Fired = 0.
  - Reset has priority over spawn and movement.
- Key held through Reset deassertion: fire_prev = 0 after reset, so it counts as a press on the first non-reset edge.

## Test plan
- Single shot: TankX=300, TankY=250, Angle=0, space pressed one cycle.
  - After the edge: slot0 active at (300,250), Fired=1.
  - Three edges later: X=312, Y=250.
  - Slot0 clears exactly 240 edges after spawn.
- Wall bounce: spawn at (637,100), Angle=0.
  - Next edge: X=637 (held), DX=−4.
  - Following edge: X=633.
- Hold and cooldown:
  - Space held 50 frames → exactly one bullet.
  - Release/press at 5 frames after spawn → ignored.
  - Press at 16 frames after spawn → slot1 spawns.
- Pool full: COOLDOWN=0, 5 presses → slots 0..3 active, 5th ignored (Fired stays 0). Expire-edge press does not reuse the expiring slot.
- Angle mapping and corner:
  - Angle=16 → DY=+4, DX=−1.
  - Angle=25 behaves as Angle=0.
  - Spawn at (0,0) with Angle=5 flips DY only at the first move, and X goes to 1.
- Reset mid-flight: Reset during two live bullets → next cycle all outputs 0, and a held fire key spawns on the first post-reset edge.

Source files
------------

// File: rtl/tank_bullets.sv
// Projectile engine for the tank game.
//
// Spawns a bullet at the tank centre on each accepted press of the fire key. Every live
// bullet moves once per frame and bounces off the arena walls. A bullet retires after a
// fixed number of frames. All outputs are registered.
//
// Ports:
//   frame_clk    - frame-rate clock, the only clock
//   Reset        - synchronous, active-high reset
//   keycode      - four packed USB HID key bytes
//   TankX/TankY  - tank centre position
//   Angle        - heading index 0..21, counter-clockwise, 0 = +X (values >= 22 act as 0)
//   BulletX/Y    - per-slot position, slot i at [10i+9:10i]
//   BulletActive - per-slot valid flag
//   Fired        - one-cycle pulse after the edge on which a bullet spawns
module tank_bullets #(
  parameter int unsigned NUM_BULLETS = 4,
  parameter logic [7:0]  FIRE_KEY    = 8'h2C,
  parameter int unsigned SPEED       = 4,
  parameter int unsigned LIFETIME    = 240,
  parameter int unsigned COOLDOWN    = 15,
  parameter int          X_MIN       = 0,
  parameter int          X_MAX       = 639,
  parameter int          Y_MIN       = 0,
  parameter int          Y_MAX       = 479
) (
  input  logic                       frame_clk,
  input  logic                       Reset,
  input  logic [31:0]                keycode,
  input  logic [9:0]                 TankX,
  input  logic [9:0]                 TankY,
  input  logic [4:0]                 Angle,
  output logic [10*NUM_BULLETS-1:0]  BulletX,
  output logic [10*NUM_BULLETS-1:0]  BulletY,
  output logic [NUM_BULLETS-1:0]     BulletActive,
  output logic                       Fired
);

  localparam int NB   = int'(NUM_BULLETS);
  localparam int IdxW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

  // First-quadrant cos/sin of k*360/22 degrees in Q16; other quadrants come by symmetry.
  function automatic int trig_q16(input int j, input bit want_sin);
    int c;
    int s;
    case (j)
      0:       begin c = 65536; s = 0;     end
      1:       begin c = 62881; s = 18464; end
      2:       begin c = 55133; s = 35431; end
      3:       begin c = 42917; s = 49529; end
      4:       begin c = 27225; s = 59614; end
      default: begin c = 9327;  s = 64869; end
    endcase
    return want_sin ? s : c;
  endfunction

  // Builds the 22-entry signed 4-bit velocity ROM, rounding half away from zero.
  // Screen Y grows downward, so DY is the negated sine term.
  function automatic logic [87:0] build_rom(input bit is_y);
    logic [87:0] rom;
    int          j;
    int          c;
    int          s;
    int          v;
    int          mag;
    int          r;
    bit          neg_c;
    bit          neg_s;
    rom = '0;
    for (int k = 0; k < 22; k++) begin
      if (k <= 5) begin
        j = k;      neg_c = 1'b0; neg_s = 1'b0;
      end else if (k <= 11) begin
        j = 11 - k; neg_c = 1'b1; neg_s = 1'b0;
      end else if (k <= 16) begin
        j = k - 11; neg_c = 1'b1; neg_s = 1'b1;
      end else begin
        j = 22 - k; neg_c = 1'b0; neg_s = 1'b1;
      end
      c = trig_q16(j, 1'b0);
      s = trig_q16(j, 1'b1);
      if (neg_c) c = -c;
      if (neg_s) s = -s;
      v   = is_y ? -(int'(SPEED) * s) : int'(SPEED) * c;
      mag = (v < 0) ? -v : v;
      r   = (mag + 32768) / 65536;
      if (v < 0) r = -r;
      rom[4*k +: 4] = r[3:0];
    end
    return rom;
  endfunction

  localparam logic [87:0] VEL_DX_ROM = build_rom(1'b0);
  localparam logic [87:0] VEL_DY_ROM = build_rom(1'b1);

  // Per-slot state
  logic [9:0]        x_q    [NB];
  logic [9:0]        x_d    [NB];
  logic [9:0]        y_q    [NB];
  logic [9:0]        y_d    [NB];
  logic signed [3:0] dx_q   [NB];
  logic signed [3:0] dx_d   [NB];
  logic signed [3:0] dy_q   [NB];
  logic signed [3:0] dy_d   [NB];
  logic [9:0]        life_q [NB];
  logic [9:0]        life_d [NB];
  logic [NB-1:0]     active_q;
  logic [NB-1:0]     active_d;

  // Shared state
  logic [7:0] cooldown_q;
  logic [7:0] cooldown_d;
  logic       fire_prev_q;
  logic       fire_prev_d;
  logic       fired_q;
  logic       fired_d;

  logic              fire_now;
  logic              press;
  logic              free_found;
  logic [IdxW-1:0]   free_idx;
  logic              accept;
  logic [4:0]        angle_idx;
  logic [6:0]        rom_base;
  logic signed [3:0] spawn_dx;
  logic signed [3:0] spawn_dy;
  logic signed [10:0] nx;
  logic signed [10:0] ny;

  always_comb begin
    fire_now = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (keycode[8*b +: 8] == FIRE_KEY) fire_now = 1'b1;
    end
    press = fire_now & ~fire_prev_q;

    // Lowest free slot, judged from the registered flags so an expiring slot is not reused
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end

    accept    = press && (cooldown_q == 8'd0) && free_found;
    angle_idx = (Angle < 5'd22) ? Angle : 5'd0;
    rom_base  = {angle_idx, 2'b00};
    spawn_dx  = VEL_DX_ROM[rom_base +: 4];
    spawn_dy  = VEL_DY_ROM[rom_base +: 4];

    fire_prev_d = fire_now;
    fired_d     = accept;
    if (accept) begin
      cooldown_d = 8'(COOLDOWN);
    end else if (cooldown_q != 8'd0) begin
      cooldown_d = cooldown_q - 8'd1;
    end else begin
      cooldown_d = 8'd0;
    end

    nx = '0;
    ny = '0;
    for (int i = 0; i < NB; i++) begin
      x_d[i]      = x_q[i];
      y_d[i]      = y_q[i];
      dx_d[i]     = dx_q[i];
      dy_d[i]     = dy_q[i];
      life_d[i]   = life_q[i];
      active_d[i] = active_q[i];

      if (active_q[i]) begin
        if (life_q[i] == 10'd1) begin
          active_d[i] = 1'b0;
          life_d[i]   = 10'd0;
        end else begin
          life_d[i] = life_q[i] - 10'd1;
          // 11-bit signed sum so a step past either wall is detectable
          nx = $signed({1'b0, x_q[i]}) + $signed({{7{dx_q[i][3]}}, dx_q[i]});
          if (int'(nx) < X_MIN || int'(nx) > X_MAX) begin
            dx_d[i] = -dx_q[i];
          end else begin
            x_d[i] = nx[9:0];
          end
          ny = $signed({1'b0, y_q[i]}) + $signed({{7{dy_q[i][3]}}, dy_q[i]});
          if (int'(ny) < Y_MIN || int'(ny) > Y_MAX) begin
            dy_d[i] = -dy_q[i];
          end else begin
            y_d[i] = ny[9:0];
          end
        end
      end

      // The chosen slot was inactive, so spawning never collides with movement
      if (accept && (free_idx == IdxW'(i))) begin
        x_d[i]      = TankX;
        y_d[i]      = TankY;
        dx_d[i]     = spawn_dx;
        dy_d[i]     = spawn_dy;
        life_d[i]   = 10'(LIFETIME);
        active_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      for (int i = 0; i < NB; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        dx_q[i]   <= '0;
        dy_q[i]   <= '0;
        life_q[i] <= '0;
      end
      active_q    <= '0;
      cooldown_q  <= '0;
      fire_prev_q <= 1'b0;
      fired_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        x_q[i]    <= x_d[i];
        y_q[i]    <= y_d[i];
        dx_q[i]   <= dx_d[i];
        dy_q[i]   <= dy_d[i];
        life_q[i] <= life_d[i];
      end
      active_q    <= active_d;
      cooldown_q  <= cooldown_d;
      fire_prev_q <= fire_prev_d;
      fired_q     <= fired_d;
    end
  end

  always_comb begin
    BulletX = '0;
    BulletY = '0;
    for (int i = 0; i < NB; i++) begin
      BulletX[10*i +: 10] = x_q[i];
      BulletY[10*i +: 10] = y_q[i];
    end
  end

  assign BulletActive = active_q;
  assign Fired        = fired_q;

endmodule
